wb_arbiter: RTL and testbench

Wishbone B4 shared-bus interconnect connecting four bus masters (m0–m3) to three slaves (s0–s2). It grants the bus to one master at a time using fixed priority with no preemption. It decodes the granted master's address to select one slave and routes the slave's response back to that master. It sits at the top of the SoC bus fabric, between CPU/DMA masters and the memory/peripheral slaves.

---
 rtl/wb_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Wishbone B4 shared bus. Four masters share access to three slaves.
//            Arbitration is fixed-priority and non-preemptive (m0 highest).
//            The granted master's address is decoded combinationally to one
//            slave. Strobes that hit no slave are answered directly.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hC000_0000,
  parameter logic [31:0] S1_BASE = 32'hF000_0000,
  parameter logic [31:0] S1_MASK = 32'hFF00_0000,
  parameter logic [31:0] S2_BASE = 32'hFF00_0000,
  parameter logic [31:0] S2_MASK = 32'hFF00_0000
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  output logic        invalid_addr,
  // master 0
  input  logic        m0_cyc_i, m0_stb_i, m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  // master 1
  input  logic        m1_cyc_i, m1_stb_i, m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  // master 2
  input  logic        m2_cyc_i, m2_stb_i, m2_we_i,
  input  logic [31:2] m2_addr_i,
  input  logic [2:0]  m2_cti_i,
  input  logic [1:0]  m2_bte_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_data_i,
  output logic [31:0] m2_data_o,
  output logic        m2_ack_o,
  // master 3
  input  logic        m3_cyc_i, m3_stb_i, m3_we_i,
  input  logic [31:2] m3_addr_i,
  input  logic [2:0]  m3_cti_i,
  input  logic [1:0]  m3_bte_i,
  input  logic [3:0]  m3_sel_i,
  input  logic [31:0] m3_data_i,
  output logic [31:0] m3_data_o,
  output logic        m3_ack_o,
  // slave 0
  output logic        s0_cyc_o, s0_stb_o, s0_we_o,
  output logic [31:2] s0_addr_o,
  output logic [2:0]  s0_cti_o,
  output logic [1:0]  s0_bte_o,
  output logic [3:0]  s0_sel_o,
  output logic [31:0] s0_data_o,
  input  logic [31:0] s0_data_i,
  input  logic        s0_ack_i,
  // slave 1
  output logic        s1_cyc_o, s1_stb_o, s1_we_o,
  output logic [31:2] s1_addr_o,
  output logic [2:0]  s1_cti_o,
  output logic [1:0]  s1_bte_o,
  output logic [3:0]  s1_sel_o,
  output logic [31:0] s1_data_o,
  input  logic [31:0] s1_data_i,
  input  logic        s1_ack_i,
  // slave 2
  output logic        s2_cyc_o, s2_stb_o, s2_we_o,
  output logic [31:2] s2_addr_o,
  output logic [2:0]  s2_cti_o,
  output logic [1:0]  s2_bte_o,
  output logic [3:0]  s2_sel_o,
  output logic [31:0] s2_data_o,
  input  logic [31:0] s2_data_i,
  input  logic        s2_ack_i
);

  typedef enum logic [2:0] {
    OWN_M0   = 3'd0,
    OWN_M1   = 3'd1,
    OWN_M2   = 3'd2,
    OWN_M3   = 3'd3,
    OWN_NONE = 3'd4
  } owner_t;

  owner_t      r_owner, w_owner_next;

  logic        w_own_cyc, w_own_stb, w_own_we;
  logic [31:2] w_own_addr;
  logic [2:0]  w_own_cti;
  logic [1:0]  w_own_bte;
  logic [3:0]  w_own_sel;
  logic [31:0] w_own_wdata;

  logic [31:0] w_byte_addr;
  logic        w_hit0, w_hit1, w_hit2;
  logic        w_sel0, w_sel1, w_sel2;
  logic        w_ret_ack;
  logic [31:0] w_ret_data;

  // Grant register; reset drops the grant immediately, even mid-transfer.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) r_owner <= OWN_NONE;
    else         r_owner <= w_owner_next;
  end

  // Re-arbitrate only when the bus is free or the owner has ended its cycle.
  always_comb begin
    w_owner_next = r_owner;
    if (r_owner == OWN_NONE || !w_own_cyc) begin
      if      (m0_cyc_i) w_owner_next = OWN_M0;
      else if (m1_cyc_i) w_owner_next = OWN_M1;
      else if (m2_cyc_i) w_owner_next = OWN_M2;
      else if (m3_cyc_i) w_owner_next = OWN_M3;
      else               w_owner_next = OWN_NONE;
    end
  end

  // Select the owner's request signals; all zero while nobody owns the bus.
  always_comb begin
    w_own_cyc   = 1'b0;
    w_own_stb   = 1'b0;
    w_own_we    = 1'b0;
    w_own_addr  = '0;
    w_own_cti   = '0;
    w_own_bte   = '0;
    w_own_sel   = '0;
    w_own_wdata = '0;
    case (r_owner)
      OWN_M0: begin
        w_own_cyc = m0_cyc_i; w_own_stb = m0_stb_i; w_own_we = m0_we_i;
        w_own_addr = m0_addr_i; w_own_cti = m0_cti_i; w_own_bte = m0_bte_i;
        w_own_sel = m0_sel_i; w_own_wdata = m0_data_i;
      end
      OWN_M1: begin
        w_own_cyc = m1_cyc_i; w_own_stb = m1_stb_i; w_own_we = m1_we_i;
        w_own_addr = m1_addr_i; w_own_cti = m1_cti_i; w_own_bte = m1_bte_i;
        w_own_sel = m1_sel_i; w_own_wdata = m1_data_i;
      end
      OWN_M2: begin
        w_own_cyc = m2_cyc_i; w_own_stb = m2_stb_i; w_own_we = m2_we_i;
        w_own_addr = m2_addr_i; w_own_cti = m2_cti_i; w_own_bte = m2_bte_i;
        w_own_sel = m2_sel_i; w_own_wdata = m2_data_i;
      end
      OWN_M3: begin
        w_own_cyc = m3_cyc_i; w_own_stb = m3_stb_i; w_own_we = m3_we_i;
        w_own_addr = m3_addr_i; w_own_cti = m3_cti_i; w_own_bte = m3_bte_i;
        w_own_sel = m3_sel_i; w_own_wdata = m3_data_i;
      end
      default: ;
    endcase
  end

  // Address decode; overlapping regions resolve to the lowest slave index.
  assign w_byte_addr = {w_own_addr, 2'b00};
  assign w_hit0 = (w_byte_addr & S0_MASK) == S0_BASE;
  assign w_hit1 = (w_byte_addr & S1_MASK) == S1_BASE;
  assign w_hit2 = (w_byte_addr & S2_MASK) == S2_BASE;
  assign w_sel0 = w_hit0;
  assign w_sel1 = !w_hit0 && w_hit1;
  assign w_sel2 = !w_hit0 && !w_hit1 && w_hit2;

  assign invalid_addr = w_own_cyc && w_own_stb && !(w_hit0 || w_hit1 || w_hit2);

  // Shared request fan-out; only the cyc/stb qualifiers are per slave.
  assign s0_cyc_o = w_own_cyc && w_sel0;
  assign s1_cyc_o = w_own_cyc && w_sel1;
  assign s2_cyc_o = w_own_cyc && w_sel2;
  assign s0_stb_o = w_own_cyc && w_own_stb && w_sel0;
  assign s1_stb_o = w_own_cyc && w_own_stb && w_sel1;
  assign s2_stb_o = w_own_cyc && w_own_stb && w_sel2;

  assign s0_we_o = w_own_we;    assign s1_we_o = w_own_we;    assign s2_we_o = w_own_we;
  assign s0_addr_o = w_own_addr; assign s1_addr_o = w_own_addr; assign s2_addr_o = w_own_addr;
  assign s0_cti_o = w_own_cti;  assign s1_cti_o = w_own_cti;  assign s2_cti_o = w_own_cti;
  assign s0_bte_o = w_own_bte;  assign s1_bte_o = w_own_bte;  assign s2_bte_o = w_own_bte;
  assign s0_sel_o = w_own_sel;  assign s1_sel_o = w_own_sel;  assign s2_sel_o = w_own_sel;
  assign s0_data_o = w_own_wdata; assign s1_data_o = w_own_wdata; assign s2_data_o = w_own_wdata;

  // Response return; an unmapped strobe is acked locally with zero data.
  always_comb begin
    w_ret_ack  = 1'b0;
    w_ret_data = '0;
    if (invalid_addr) begin
      w_ret_ack  = 1'b1;
      w_ret_data = '0;
    end else if (w_sel0) begin
      w_ret_ack  = s0_ack_i;
      w_ret_data = s0_data_i;
    end else if (w_sel1) begin
      w_ret_ack  = s1_ack_i;
      w_ret_data = s1_data_i;
    end else if (w_sel2) begin
      w_ret_ack  = s2_ack_i;
      w_ret_data = s2_data_i;
    end
  end

  assign m0_ack_o  = (r_owner == OWN_M0) && w_ret_ack;
  assign m1_ack_o  = (r_owner == OWN_M1) && w_ret_ack;
  assign m2_ack_o  = (r_owner == OWN_M2) && w_ret_ack;
  assign m3_ack_o  = (r_owner == OWN_M3) && w_ret_ack;
  assign m0_data_o = (r_owner == OWN_M0) ? w_ret_data : 32'h0;
  assign m1_data_o = (r_owner == OWN_M1) ? w_ret_data : 32'h0;
  assign m2_data_o = (r_owner == OWN_M2) ? w_ret_data : 32'h0;
  assign m3_data_o = (r_owner == OWN_M3) ? w_ret_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        wb_clk;
  logic        wb_rst;
  logic        invalid_addr;

  logic        m_cyc [0:3];
  logic        m_stb [0:3];
  logic        m_we  [0:3];
  logic [29:0] m_addr[0:3];
  logic [2:0]  m_cti [0:3];
  logic [1:0]  m_bte [0:3];
  logic [3:0]  m_sel [0:3];
  logic [31:0] m_wdat[0:3];
  logic [31:0] m_rdat[0:3];
  logic        m_ack [0:3];

  logic        s_cyc [0:2];
  logic        s_stb [0:2];
  logic        s_we  [0:2];
  logic [29:0] s_addr[0:2];
  logic [2:0]  s_cti [0:2];
  logic [1:0]  s_bte [0:2];
  logic [3:0]  s_sel [0:2];
  logic [31:0] s_wdat[0:2];
  logic [31:0] s_rdat[0:2];
  logic        s_ack [0:2];

  int n_checks = 0;
  int n_fail   = 0;

  // Distinct s0-region word addresses used to identify the current owner.
  logic [29:0] c_id_addr [0:3];

  wb_arbiter dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .invalid_addr(invalid_addr),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_addr_i(m_addr[0]),
    .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_sel_i(m_sel[0]), .m0_data_i(m_wdat[0]),
    .m0_data_o(m_rdat[0]), .m0_ack_o(m_ack[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_addr_i(m_addr[1]),
    .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_sel_i(m_sel[1]), .m1_data_i(m_wdat[1]),
    .m1_data_o(m_rdat[1]), .m1_ack_o(m_ack[1]),
    .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_we_i(m_we[2]), .m2_addr_i(m_addr[2]),
    .m2_cti_i(m_cti[2]), .m2_bte_i(m_bte[2]), .m2_sel_i(m_sel[2]), .m2_data_i(m_wdat[2]),
    .m2_data_o(m_rdat[2]), .m2_ack_o(m_ack[2]),
    .m3_cyc_i(m_cyc[3]), .m3_stb_i(m_stb[3]), .m3_we_i(m_we[3]), .m3_addr_i(m_addr[3]),
    .m3_cti_i(m_cti[3]), .m3_bte_i(m_bte[3]), .m3_sel_i(m_sel[3]), .m3_data_i(m_wdat[3]),
    .m3_data_o(m_rdat[3]), .m3_ack_o(m_ack[3]),
    .s0_cyc_o(s_cyc[0]), .s0_stb_o(s_stb[0]), .s0_we_o(s_we[0]), .s0_addr_o(s_addr[0]),
    .s0_cti_o(s_cti[0]), .s0_bte_o(s_bte[0]), .s0_sel_o(s_sel[0]), .s0_data_o(s_wdat[0]),
    .s0_data_i(s_rdat[0]), .s0_ack_i(s_ack[0]),
    .s1_cyc_o(s_cyc[1]), .s1_stb_o(s_stb[1]), .s1_we_o(s_we[1]), .s1_addr_o(s_addr[1]),
    .s1_cti_o(s_cti[1]), .s1_bte_o(s_bte[1]), .s1_sel_o(s_sel[1]), .s1_data_o(s_wdat[1]),
    .s1_data_i(s_rdat[1]), .s1_ack_i(s_ack[1]),
    .s2_cyc_o(s_cyc[2]), .s2_stb_o(s_stb[2]), .s2_we_o(s_we[2]), .s2_addr_o(s_addr[2]),
    .s2_cti_o(s_cti[2]), .s2_bte_o(s_bte[2]), .s2_sel_o(s_sel[2]), .s2_data_o(s_wdat[2]),
    .s2_data_i(s_rdat[2]), .s2_ack_i(s_ack[2])
  );

  // 100 MHz bus clock.
  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_masters();
    for (int i = 0; i < 4; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = c_id_addr[i];
      m_cti[i] = 3'b000; m_bte[i] = 2'b00; m_sel[i] = 4'hF; m_wdat[i] = 32'h0;
    end
  endtask

  task automatic test_reset();
    wb_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; end
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (s_cyc[k] !== 1'b0 || s_stb[k] !== 1'b0 || s_addr[k] !== 30'h0 || s_wdat[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_slave%0d: cyc=%b stb=%b addr=%h data=%h, required all 0", k, s_cyc[k], s_stb[k], s_addr[k], s_wdat[k]);
      end
    end
    n_checks++;
    if (m_ack[0] !== 1'b0 || m_ack[1] !== 1'b0 || m_ack[2] !== 1'b0 || m_ack[3] !== 1'b0 || invalid_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_acks: ack=%b%b%b%b invalid=%b, required 0", m_ack[0], m_ack[1], m_ack[2], m_ack[3], invalid_addr);
    end
    wb_rst = 1'b1;
    #1;
    n_checks++;
    if (s_cyc[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release_pre_edge: s0_cyc=%b, required 0", s_cyc[0]);
    end
    tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_addr[0] !== c_id_addr[0]) begin
      n_fail++;
      $display("FAIL rst_grant_m0: s0_cyc=%b addr=%h, required 1 addr=%h", s_cyc[0], s_addr[0], c_id_addr[0]);
    end
    idle_masters();
    tick();
  endtask

  task automatic test_priority();
    m_cyc[0] = 1'b1;
    tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_addr[0] !== c_id_addr[0]) begin
      n_fail++; $display("FAIL prio_m0_grant: cyc=%b addr=%h, required 1 %h", s_cyc[0], s_addr[0], c_id_addr[0]);
    end
    m_cyc[1] = 1'b1; tick();
    m_cyc[2] = 1'b1; tick();
    n_checks++;
    if (s_addr[0] !== c_id_addr[0]) begin
      n_fail++; $display("FAIL prio_hold_m0: addr=%h, required %h", s_addr[0], c_id_addr[0]);
    end
    m_cyc[1] = 1'b0; tick();
    m_cyc[0] = 1'b0; #1;
    n_checks++;
    if (s_cyc[0] !== 1'b0) begin
      n_fail++; $display("FAIL prio_handover_gap: s0_cyc=%b, required 0", s_cyc[0]);
    end
    tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_addr[0] !== c_id_addr[2]) begin
      n_fail++; $display("FAIL prio_m2_grant: cyc=%b addr=%h, required 1 %h", s_cyc[0], s_addr[0], c_id_addr[2]);
    end
    m_cyc[1] = 1'b1; tick(); tick();
    n_checks++;
    if (s_addr[0] !== c_id_addr[2]) begin
      n_fail++; $display("FAIL prio_hold_m2: addr=%h, required %h", s_addr[0], c_id_addr[2]);
    end
    m_cyc[2] = 1'b0; tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_addr[0] !== c_id_addr[1]) begin
      n_fail++; $display("FAIL prio_m1_grant: cyc=%b addr=%h, required 1 %h", s_cyc[0], s_addr[0], c_id_addr[1]);
    end
    m_cyc[1] = 1'b0; tick();
    n_checks++;
    if (s_cyc[0] !== 1'b0 || s_addr[0] !== 30'h0) begin
      n_fail++; $display("FAIL prio_none: cyc=%b addr=%h, required 0 0", s_cyc[0], s_addr[0]);
    end
  endtask

  task automatic test_decode();
    idle_masters();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 30'h0400_0000; // 0x1000_0000
    tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_stb[0] !== 1'b1 || s_stb[1] !== 1'b0 || s_stb[2] !== 1'b0) begin
      n_fail++; $display("FAIL dec_s0: stb=%b%b%b cyc0=%b, required stb=100 cyc0=1", s_stb[0], s_stb[1], s_stb[2], s_cyc[0]);
    end
    s_ack[0] = 1'b1; #1;
    n_checks++;
    if (m_ack[0] !== 1'b1 || m_rdat[0] !== 32'hDEAD_BEEF || m_rdat[1] !== 32'h0) begin
      n_fail++; $display("FAIL dec_s0_resp: ack=%b m0_data=%h m1_data=%h, required 1 deadbeef 0", m_ack[0], m_rdat[0], m_rdat[1]);
    end
    s_ack[0] = 1'b0;
    m_addr[0] = 30'h3C00_0004; #1; // 0xF000_0010
    n_checks++;
    if (s_stb[0] !== 1'b0 || s_stb[1] !== 1'b1 || s_stb[2] !== 1'b0 || m_rdat[0] !== 32'h1111_1111) begin
      n_fail++; $display("FAIL dec_s1: stb=%b%b%b data=%h, required 010 11111111", s_stb[0], s_stb[1], s_stb[2], m_rdat[0]);
    end
    m_addr[0] = 30'h3FC0_0001; s_ack[1] = 1'b1; #1; // 0xFF00_0004
    n_checks++;
    if (s_stb[0] !== 1'b0 || s_stb[1] !== 1'b0 || s_stb[2] !== 1'b1 || m_ack[0] !== 1'b0 || m_rdat[0] !== 32'h2222_2222) begin
      n_fail++; $display("FAIL dec_s2: stb=%b%b%b ack=%b data=%h, required 001 0 22222222", s_stb[0], s_stb[1], s_stb[2], m_ack[0], m_rdat[0]);
    end
    s_ack[1] = 1'b0;
    idle_masters();
    tick();
  endtask

  task automatic test_invalid();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = 30'h2000_0000; // 0x8000_0000
    tick();
    n_checks++;
    if (invalid_addr !== 1'b1 || m_ack[1] !== 1'b1 || m_rdat[1] !== 32'h0) begin
      n_fail++; $display("FAIL inv_resp: invalid=%b ack=%b data=%h, required 1 1 0", invalid_addr, m_ack[1], m_rdat[1]);
    end
    n_checks++;
    if (s_stb[0] !== 1'b0 || s_stb[1] !== 1'b0 || s_stb[2] !== 1'b0) begin
      n_fail++; $display("FAIL inv_no_strobe: stb=%b%b%b, required 000", s_stb[0], s_stb[1], s_stb[2]);
    end
    idle_masters();
    tick();
  endtask

  task automatic test_write();
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_we[3] = 1'b1; m_sel[3] = 4'b0011;
    m_wdat[3] = 32'h1234_5678; m_addr[3] = 30'h3C00_0002; // 0xF000_0008
    tick();
    n_checks++;
    if (s_stb[1] !== 1'b1 || s_wdat[1] !== 32'h1234_5678 || s_sel[1] !== 4'b0011 ||
        s_we[1] !== 1'b1 || s_addr[1] !== 30'h3C00_0002 || s_stb[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_s1: stb=%b data=%h sel=%b we=%b addr=%h s0stb=%b, required 1 12345678 0011 1 3c000002 0",
               s_stb[1], s_wdat[1], s_sel[1], s_we[1], s_addr[1], s_stb[0]);
    end
    idle_masters();
    tick();
  endtask

  task automatic test_reset_burst();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010; m_bte[0] = 2'b01; m_addr[0] = 30'h40;
    tick(); tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_cti[0] !== 3'b010 || s_bte[0] !== 2'b01) begin
      n_fail++; $display("FAIL burst_pass: cyc=%b cti=%b bte=%b, required 1 010 01", s_cyc[0], s_cti[0], s_bte[0]);
    end
    #2 wb_rst = 1'b0;
    #1;
    n_checks++;
    if (s_cyc[0] !== 1'b0 || s_stb[0] !== 1'b0 || s_addr[0] !== 30'h0 || s_cti[0] !== 3'b000 || m_ack[0] !== 1'b0) begin
      n_fail++; $display("FAIL burst_rst_clear: cyc=%b stb=%b addr=%h cti=%b ack=%b, required all 0", s_cyc[0], s_stb[0], s_addr[0], s_cti[0], m_ack[0]);
    end
    wb_rst = 1'b1;
    tick();
    n_checks++;
    if (s_cyc[0] !== 1'b1 || s_addr[0] !== 30'h40 || s_cti[0] !== 3'b010) begin
      n_fail++; $display("FAIL burst_regrant: cyc=%b addr=%h cti=%b, required 1 40 010", s_cyc[0], s_addr[0], s_cti[0]);
    end
    idle_masters();
    tick();
  endtask

  initial begin
    c_id_addr[0] = 30'h4; c_id_addr[1] = 30'h8; c_id_addr[2] = 30'hC; c_id_addr[3] = 30'h10;
    wb_rst = 1'b0;
    idle_masters();
    s_rdat[0] = 32'hDEAD_BEEF; s_rdat[1] = 32'h1111_1111; s_rdat[2] = 32'h2222_2222;
    for (int k = 0; k < 3; k++) s_ack[k] = 1'b0;
    test_reset();
    test_priority();
    test_decode();
    test_invalid();
    test_write();
    test_reset_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
